// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters.
// Requests are granted in IDLE, run for one EXEC cycle, then the result is held in RESP until accepted.
module alu_arbiter #(
    parameter  int unsigned NREQ   = 2,
    localparam int unsigned WORD_W = 32,
    localparam int unsigned OP_W   = 4,
    localparam int unsigned ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0][WORD_W-1:0]  req_a,
    input  logic [NREQ-1:0][WORD_W-1:0]  req_b,
    input  logic [NREQ-1:0][OP_W-1:0]    req_ops,
    output logic [NREQ-1:0]              resp_valid,
    input  logic [NREQ-1:0]              resp_ready,
    output logic [WORD_W-1:0]            resp_out,
    output logic                         resp_zero,
    output logic                         resp_overflow,
    output logic                         resp_negative,
    output logic [WORD_W-1:0]            alu_a,
    output logic [WORD_W-1:0]            alu_b,
    output logic [OP_W-1:0]              alu_ops,
    input  logic [WORD_W-1:0]            alu_out,
    input  logic                         alu_zero,
    input  logic                         alu_overflow,
    input  logic                         alu_negative,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            prio_q;
    logic [ID_W-1:0] owner_q;
    logic [ID_W-1:0] grant_id;
    logic            accept;
    logic            resp_done;

    // Next state, grant selection and handshake strobes.
    always_comb begin
        state_d    = state_q;
        grant_id   = ID_W'(prio_q);
        accept     = 1'b0;
        resp_done  = 1'b0;
        req_ready  = '0;
        resp_valid = '0;
        unique case (state_q)
            IDLE: begin
                // A lone requester wins regardless of the priority pointer.
                if (req_valid[0] && !req_valid[1]) begin
                    grant_id = '0;
                end else if (req_valid[1] && !req_valid[0]) begin
                    grant_id = ID_W'(1);
                end
                if ((|req_valid) && !RST) begin
                    accept              = 1'b1;
                    req_ready[grant_id] = 1'b1;
                    state_d             = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                resp_valid[owner_q] = 1'b1;
                if (resp_ready[owner_q]) begin
                    resp_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and priority pointer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (resp_done) begin
                prio_q <= ~owner_q[0];
            end
        end
    end

    // Operand latch on accept, result capture at the end of EXEC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_q       <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_ops       <= '0;
            resp_out      <= '0;
            resp_zero     <= 1'b0;
            resp_overflow <= 1'b0;
            resp_negative <= 1'b0;
        end else begin
            if (accept) begin
                owner_q <= grant_id;
                alu_a   <= req_a[grant_id];
                alu_b   <= req_b[grant_id];
                alu_ops <= req_ops[grant_id];
            end
            if (state_q == EXEC) begin
                resp_out      <= alu_out;
                resp_zero     <= alu_zero;
                resp_overflow <= alu_overflow;
                resp_negative <= alu_negative;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner sequences and a randomized run.
module tb_alu_arbiter;

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    logic             CLK;
    logic             RST;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][3:0]  req_ops;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [31:0]      resp_out;
    logic             resp_zero;
    logic             resp_overflow;
    logic             resp_negative;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_ops;
    logic [31:0]      alu_out;
    logic             alu_zero;
    logic             alu_overflow;
    logic             alu_negative;
    logic             busy;

    int total = 0;
    int bad   = 0;

    alu_arbiter dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ops       (req_ops),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_out      (resp_out),
        .resp_zero     (resp_zero),
        .resp_overflow (resp_overflow),
        .resp_negative (resp_negative),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_ops       (alu_ops),
        .alu_out       (alu_out),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .alu_negative  (alu_negative),
        .busy          (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural ALU; result packed as {zero, overflow, negative, out}.
    function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (op)
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {(r == 32'd0), v, r[31], r};
    endfunction

    logic [34:0] alu_res;
    always_comb alu_res = alu_fn(alu_a, alu_b, alu_ops);
    assign alu_out      = alu_res[31:0];
    assign alu_negative = alu_res[32];
    assign alu_overflow = alu_res[33];
    assign alu_zero     = alu_res[34];

    function automatic logic [1:0] onehot(input logic id);
        return 2'b01 << id;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, want);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] zvn();
        return 32'({resp_zero, resp_overflow, resp_negative});
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        req_valid = '0;
        step();
        step();
        RST = 1'b0;
    endtask

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] out;
        logic [2:0]  flags;
    } vec_t;

    vec_t vt[10];

    // Random-phase state: pending requests and the transaction-level reference.
    logic [31:0] pa[2];
    logic [31:0] pb[2];
    logic [3:0]  po[2];
    logic [1:0]  hv;
    int          m_phase;
    logic        m_prio;
    logic        m_owner;
    logic        g;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [3:0]  m_op;
    logic [34:0] m_res;
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_rv;

    initial begin
        vt[0] = '{1'b0, 32'd5,        32'd7,        OP_ADD, 32'd12,       3'b000};
        vt[1] = '{1'b1, 32'd3,        32'd3,        OP_SUB, 32'd0,        3'b100};
        vt[2] = '{1'b0, 32'h7FFFFFFF, 32'd1,        OP_ADD, 32'h80000000, 3'b011};
        vt[3] = '{1'b1, 32'd0,        32'd1,        OP_SUB, 32'hFFFFFFFF, 3'b001};
        vt[4] = '{1'b0, 32'h80000000, 32'd1,        OP_SUB, 32'h7FFFFFFF, 3'b010};
        vt[5] = '{1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, OP_AND, 32'h00F000F0, 3'b000};
        vt[6] = '{1'b0, 32'd0,        32'd0,        OP_NOR, 32'hFFFFFFFF, 3'b001};
        vt[7] = '{1'b1, 32'hFFFFFFFF, 32'd1,        OP_SLT, 32'd1,        3'b000};
        vt[8] = '{1'b0, 32'h80000000, 32'd4,        OP_SRL, 32'h08000000, 3'b000};
        vt[9] = '{1'b1, 32'd1,        32'd2,        4'd15,  32'd0,        3'b100};

        RST        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_ops    = '0;
        resp_ready = '0;

        // Reset values.
        step();
        @(negedge CLK);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_out", resp_out, 32'd0);
        chk("rst_flags", zvn(), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ops", 32'(alu_ops), 32'd0);
        step();
        RST = 1'b0;

        // Single-requester vectors: accept, EXEC, RESP with resp_ready already high.
        for (int i = 0; i < 10; i++) begin
            req_valid = '0;
            req_valid[vt[i].id] = 1'b1;
            req_a[vt[i].id]     = vt[i].a;
            req_b[vt[i].id]     = vt[i].b;
            req_ops[vt[i].id]   = vt[i].op;
            req_a[~vt[i].id]    = 32'hDEADBEEF;
            resp_ready = 2'b11;
            @(negedge CLK);
            chk($sformatf("vec%0d_grant", i), 32'(req_ready), 32'(onehot(vt[i].id)));
            chk($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
            step();
            req_valid = '0;
            @(negedge CLK);
            chk($sformatf("vec%0d_alu_a", i), alu_a, vt[i].a);
            chk($sformatf("vec%0d_alu_b", i), alu_b, vt[i].b);
            chk($sformatf("vec%0d_alu_ops", i), 32'(alu_ops), 32'(vt[i].op));
            chk($sformatf("vec%0d_exec_busy", i), 32'(busy), 32'd1);
            chk($sformatf("vec%0d_exec_rv", i), 32'(resp_valid), 32'd0);
            step();
            @(negedge CLK);
            chk($sformatf("vec%0d_rv", i), 32'(resp_valid), 32'(onehot(vt[i].id)));
            chk($sformatf("vec%0d_out", i), resp_out, vt[i].out);
            chk($sformatf("vec%0d_flags", i), zvn(), 32'(vt[i].flags));
            step();
        end

        // Reset in the middle of RESP drops the transaction.
        req_valid  = 2'b01;
        req_a[0]   = 32'd9;
        req_b[0]   = 32'd4;
        req_ops[0] = OP_ADD;
        resp_ready = 2'b00;
        step();
        req_valid = '0;
        step();
        @(negedge CLK);
        chk("mid_rst_pre_rv", 32'(resp_valid), 32'b01);
        RST = 1'b1;
        step();
        @(negedge CLK);
        chk("mid_rst_rv", 32'(resp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out", resp_out, 32'd0);
        chk("mid_rst_flags", zvn(), 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_ops", 32'(alu_ops), 32'd0);
        chk("mid_rst_rdy", 32'(req_ready), 32'd0);
        req_valid = 2'b01;
        #1;
        chk("mid_rst_forced_rdy", 32'(req_ready), 32'd0);
        step();
        RST        = 1'b0;
        req_valid  = '0;
        resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk($sformatf("mid_rst_no_resp%0d", k), 32'({busy, resp_valid}), 32'd0);
            step();
        end

        // Contention: both requesters continuously valid, grants alternate from 0.
        do_reset();
        req_a[0] = 32'd3;          req_b[0] = 32'd3; req_ops[0] = OP_SUB;
        req_a[1] = 32'h7FFFFFFF;   req_b[1] = 32'd1; req_ops[1] = OP_ADD;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            logic gk;
            gk = 1'(k % 2);
            @(negedge CLK);
            chk($sformatf("cont%0d_grant", k), 32'(req_ready), 32'(onehot(gk)));
            step();
            step();
            @(negedge CLK);
            chk($sformatf("cont%0d_rv", k), 32'(resp_valid), 32'(onehot(gk)));
            chk($sformatf("cont%0d_out", k), resp_out, gk ? 32'h80000000 : 32'd0);
            chk($sformatf("cont%0d_flags", k), zvn(), gk ? 32'b011 : 32'b100);
            step();
        end
        req_valid = '0;

        // Back-pressure on requester 1 while requester 0 waits.
        req_valid  = 2'b10;
        req_a[1]   = 32'h12345678; req_b[1] = 32'h11111111; req_ops[1] = OP_ADD;
        resp_ready = 2'b01;
        @(negedge CLK);
        chk("bp_grant1", 32'(req_ready), 32'b10);
        step();
        req_valid = 2'b01;
        req_a[0]  = 32'd100; req_b[0] = 32'd1; req_ops[0] = OP_SUB;
        @(negedge CLK);
        chk("bp_exec_rdy", 32'(req_ready), 32'd0);
        step();
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk($sformatf("bp%0d_rv", k), 32'(resp_valid), 32'b10);
            chk($sformatf("bp%0d_out", k), resp_out, 32'h23456789);
            chk($sformatf("bp%0d_busy", k), 32'(busy), 32'd1);
            chk($sformatf("bp%0d_rdy", k), 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 2'b11;
        @(negedge CLK);
        chk("bp_release_rv", 32'(resp_valid), 32'b10);
        step();
        @(negedge CLK);
        chk("bp_next_grant", 32'(req_ready), 32'b01);
        step();
        req_valid = '0;
        step();
        @(negedge CLK);
        chk("bp_req0_rv", 32'(resp_valid), 32'b01);
        chk("bp_req0_out", resp_out, 32'd99);
        step();

        // Requester 1 served alone, then contention hands the grant to requester 0.
        req_valid  = 2'b10;
        req_a[1]   = 32'd20; req_b[1] = 32'd22; req_ops[1] = OP_OR;
        resp_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("solo%0d_grant", k), 32'(req_ready), 32'b10);
            step();
            step();
            @(negedge CLK);
            chk($sformatf("solo%0d_out", k), resp_out, 32'd22);
            step();
        end
        req_valid = 2'b11;
        req_a[0]  = 32'd6; req_b[0] = 32'd3; req_ops[0] = OP_XOR;
        @(negedge CLK);
        chk("prio_first", 32'(req_ready), 32'b01);
        step();
        step();
        @(negedge CLK);
        chk("prio_first_rv", 32'(resp_valid), 32'b01);
        chk("prio_first_out", resp_out, 32'd5);
        step();
        @(negedge CLK);
        chk("prio_second", 32'(req_ready), 32'b10);
        step();
        req_valid = '0;
        step();
        step();

        // Randomized traffic against a transaction-level reference.
        do_reset();
        hv      = '0;
        m_phase = 0;
        m_prio  = 1'b0;
        m_owner = 1'b0;
        m_a     = '0;
        m_b     = '0;
        m_op    = '0;
        m_res   = '0;
        g       = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int j = 0; j < 2; j++) begin
                if (!hv[j] && ($urandom_range(1, 0) == 1)) begin
                    pa[j] = $urandom;
                    pb[j] = ($urandom_range(3, 0) == 0) ? pa[j] : $urandom;
                    po[j] = 4'($urandom_range(15, 0));
                    hv[j] = 1'b1;
                end
                req_a[j]   = pa[j];
                req_b[j]   = pb[j];
                req_ops[j] = po[j];
            end
            req_valid     = hv;
            resp_ready[0] = ($urandom_range(9, 0) < 7);
            resp_ready[1] = ($urandom_range(9, 0) < 7);
            @(negedge CLK);
            exp_rdy = '0;
            exp_rv  = '0;
            if (m_phase == 0 && hv != 2'b00) begin
                g = (hv == 2'b11) ? m_prio : hv[1];
                exp_rdy[g] = 1'b1;
            end
            if (m_phase == 2) exp_rv[m_owner] = 1'b1;
            chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rnd_resp_valid", 32'(resp_valid), 32'(exp_rv));
            chk("rnd_busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
            chk("rnd_alu_in", alu_a ^ alu_b ^ 32'(alu_ops), m_a ^ m_b ^ 32'(m_op));
            if (m_phase == 2) begin
                chk("rnd_resp_out", resp_out, m_res[31:0]);
                chk("rnd_flags", zvn(), 32'({m_res[34], m_res[33], m_res[32]}));
            end
            case (m_phase)
                0: if (hv != 2'b00) begin
                    m_owner = g;
                    m_a     = pa[g];
                    m_b     = pb[g];
                    m_op    = po[g];
                    m_res   = alu_fn(pa[g], pb[g], po[g]);
                    hv[g]   = 1'b0;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (resp_ready[m_owner]) begin
                    m_prio  = ~m_owner;
                    m_phase = 0;
                end
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares one `alu` instance between two requesters, for example the execute stage and a multicycle/debug unit. It accepts operand/opcode requests over valid/ready handshakes and grants them round-robin. It drives the ALU from registered operands and returns the captured result and flags to the granted requester over a valid/ready response handshake. It sits between the requesters and the `alu_if` a/b/ops inputs and out/zero/overflow/negative outputs.

## Interface
- `NREQ`, 2, number of requesters; fixed at 2 for this revision.
- `CLK`  in  1  system clock; all state updates on rising edge.
- `RST`  in  1  reset; one clock, synchronous, active-high.
- `req_valid`  in  2  per-requester request valid.
- `req_ready`  out  2  per-requester request accept; one-hot or zero.
- `req_a`  in  2x32  per-requester operand A (`word_t`).
- `req_b`  in  2x32  per-requester operand B (`word_t`).
- `req_ops`  in  2x4  per-requester opcode (`aluop_t`).
- `resp_valid`  out  2  per-requester response valid; one-hot or zero.
- `resp_ready`  in  2  per-requester response accept.
- `resp_out`  out  32  shared result bus.
- `resp_zero`, `resp_overflow`, `resp_negative`  out  1 each  shared captured flags.
- `alu_a`, `alu_b`  out  32 each  to `aluif.a` / `aluif.b`.
- `alu_ops`  out  4  to `aluif.ops`.
- `alu_out`  in  32  from `aluif.out`.
- `alu_zero`, `alu_overflow`, `alu_negative`  in  1 each  from `aluif`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- State machine with three states: IDLE, EXEC and RESP. Reset state is IDLE.
- Priority pointer `prio` is one bit. Reset value is 0, giving requester 0 priority.
- **Grant in IDLE (combinational):**
  - Only one valid: grant that requester.
  - Both valid: grant requester `prio`.
  - `req_ready[g]` = 1 for the granted requester only.
  - The handshake completes in that cycle. The arbiter latches a/b/ops and owner id `g`, then moves to EXEC.
  - Neither valid: stay in IDLE with `req_ready` = 0.
- **EXEC (one cycle):**
  - `alu_a`, `alu_b` and `alu_ops` are driven from the latched registers.
  - At the clock edge, `alu_out` and the three flags are captured into the resp registers. Next state is RESP.
- **RESP:**
  - `resp_valid[owner]` = 1 and the resp bus holds the captured values, stable until accepted.
  - On `resp_ready[owner]` = 1: go to IDLE and set `prio` to `~owner`.
  - `resp_ready` of the non-owner is ignored.
- `req_ready` = 0 in EXEC and RESP. Requests are neither accepted nor lost; requesters hold `req_valid` and data until they see ready.
- `alu_a`, `alu_b` and `alu_ops` hold their latched values outside EXEC. This keeps ALU inputs quiet.
- Opcodes are passed through unchecked; an undefined opcode yields whatever the ALU produces.
- No arithmetic is done in this block. All data paths are 32-bit pass-through with no width conversion.

## Timing
- **Reset values:**
  - `req_ready` = 0 (forced 0 while RST is high), `resp_valid` = 0, `busy` = 0.
  - `resp_out` and all three resp flags = 0.
  - `alu_a` = `alu_b` = 0, `alu_ops` = 0, `prio` = 0.
- **Latency:** request accepted at edge T; EXEC during cycle T+1; `resp_valid` high from cycle T+2.
- **Throughput:** minimum 3 cycles per operation (accept, EXEC, RESP with `resp_ready` already high). The next accept is possible in the cycle after the response is accepted.
- **Fairness:**
  - With both requesters continuously valid, grants strictly alternate: 0, 1, 0, 1, …
  - A lone requester is served back-to-back regardless of `prio`.
- **Simultaneous events:**
  - A new `req_valid` from the non-owner during EXEC or RESP waits. It is served at the next IDLE, ahead of the owner, because `prio` flips.
- **Reset mid-operation:** RST in EXEC or RESP returns to IDLE next cycle.
  - The in-flight transaction is dropped and no response is issued.
  - All outputs take their reset values; `prio` returns to 0.
- **Stalled response:** the arbiter remains in RESP indefinitely with stable data until the owner asserts `resp_ready`.

## Test plan
- **Reset:** assert RST for 2 cycles mid-RESP with `resp_valid[0]` = 1 → next cycle all outputs are 0, `busy` = 0, and no response follows.
- **Single add:** req 0 sends a = 5, b = 7, ops = ADD at cycle 0 with `resp_ready` high → `req_ready[0]` = 1 in cycle 0, `alu_a` = 5 in cycle 1, and in cycle 2 `resp_valid[0]` = 1, `resp_out` = 12, zero = 0.
- **Contention:** both requesters valid continuously for 4 ops each (req 0: SUB 3−3; req 1: ADD 0x7FFFFFFF+1) → grant order 0, 1, 0, 1, …
  - req 0 responses: out = 0, zero = 1.
  - req 1 responses: out = 0x80000000, overflow = 1, negative = 1.
- **Back-pressure:** hold `resp_ready[1]` = 0 for 10 cycles while req 0 is valid → `resp_out` stable, `busy` = 1, `req_ready` = 0 throughout. After `resp_ready[1]` = 1, req 0 is granted the next cycle.
- **Priority after solo run:** req 1 is served alone 3 times, then both become valid → req 0 is granted first.
